// File: rtl/vga_timing_gen_param.sv
// Raster timing generator: free-running H/V counters gated by a frame-aligned run FSM,
// driving registered syncs, blanking, coordinates and FIFO-fed RGB with underflow black fill.
module vga_timing_gen_param #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CH_W     = 8,
    parameter int   CNT_W    = 12,
    parameter int   UFL_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                fifo_empty,
    input  logic [3*CH_W-1:0]   fifo_data,
    output logic                fifo_rreq,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                hsync,
    output logic                vsync,
    output logic                blank_n,
    output logic                sync_n,
    output logic [CNT_W-1:0]    pix_x,
    output logic [CNT_W-1:0]    pix_y,
    output logic                frame_start,
    output logic                underflow,
    output logic [UFL_W-1:0]    underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    h_q, h_d, v_q, v_d;
    logic [3*CH_W-1:0]   rgb_q, rgb_d;
    logic                hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [CNT_W-1:0]    x_q, x_d, y_q, y_d;
    logic                fs_q, fs_d, ufl_q, ufl_d;
    logic [UFL_W-1:0]    ucnt_q, ucnt_d;
    logic                run, active, pop;

    function automatic logic [UFL_W-1:0] sat_inc(input logic [UFL_W-1:0] c);
        return (&c) ? c : c + UFL_W'(1);
    endfunction

    always_comb begin
        run     = (state_q == ST_RUN);
        active  = (h_q < H_ACT_C) && (v_q < V_ACT_C);
        pop     = run && active && !fifo_empty;
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                h_d = '0;
                v_d = '0;
                if (!enable)          state_d = ST_IDLE;
                else if (!fifo_empty) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
                    // enable only matters on the very last pixel of a frame
                    if (v_q == V_LAST && !enable) state_d = ST_IDLE;
                end else begin
                    h_d = h_q + ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rgb_d   = pop ? fifo_data : '0;
        hs_d    = (run && h_q >= H_SS && h_q <= H_SE) ? HS_POL : ~HS_POL;
        vs_d    = (run && v_q >= V_SS && v_q <= V_SE) ? VS_POL : ~VS_POL;
        blank_d = run && active;
        x_d     = h_q;
        y_d     = v_q;
        fs_d    = run && (h_q == '0) && (v_q == '0);
        ufl_d   = run && active && fifo_empty;
        ucnt_d  = ufl_d ? sat_inc(ucnt_q) : ucnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            rgb_q   <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            ufl_q   <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            ufl_q   <= ufl_d;
            ucnt_q  <= ucnt_d;
        end
    end

    // A pop requested while rst is high would be lost, so suppress it.
    assign fifo_rreq     = pop && !rst;
    assign red           = rgb_q[3*CH_W-1:2*CH_W];
    assign green         = rgb_q[2*CH_W-1:CH_W];
    assign blue          = rgb_q[CH_W-1:0];
    assign hsync         = hs_q;
    assign vsync         = vs_q;
    assign blank_n       = blank_q;
    assign sync_n        = 1'b1;
    assign pix_x         = x_q;
    assign pix_y         = y_q;
    assign frame_start   = fs_q;
    assign underflow     = ufl_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Randomised bench for vga_timing_gen_param (16x8 raster) against a linear-pixel-index model;
// a second instance with a 2-bit underflow counter exercises saturation.
module tb_vga_timing_gen_param;

    localparam int HT = 16;
    localparam int VT = 8;
    localparam int FRAME = HT * VT;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;

    logic clk = 1'b0;
    logic rst, enable, fifo_empty;
    logic [23:0] fifo_data;

    logic        rreq_a, hs_a, vs_a, bl_a, sn_a, fs_a, uf_a;
    logic [7:0]  r_a, g_a, b_a;
    logic [11:0] x_a, y_a;
    logic [15:0] cnt_a;

    logic        rreq_b, hs_b, vs_b, bl_b, sn_b, fs_b, uf_b;
    logic [7:0]  r_b, g_b, b_b;
    logic [11:0] x_b, y_b;
    logic [1:0]  cnt_b;

    int n_vec = 0;
    int n_err = 0;

    int m_mode = M_IDLE;
    int m_pos  = 0;
    int m_ufl  = 0;

    always #5 clk = ~clk;

    vga_timing_gen_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CH_W(8), .CNT_W(12), .UFL_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rreq(rreq_a), .red(r_a), .green(g_a), .blue(b_a), .hsync(hs_a), .vsync(vs_a),
        .blank_n(bl_a), .sync_n(sn_a), .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a),
        .underflow(uf_a), .underflow_cnt(cnt_a)
    );

    vga_timing_gen_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CH_W(8), .CNT_W(12), .UFL_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rreq(rreq_b), .red(r_b), .green(g_b), .blue(b_b), .hsync(hs_b), .vsync(vs_b),
        .blank_n(bl_b), .sync_n(sn_b), .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b),
        .underflow(uf_b), .underflow_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One pixel clock: drive inputs, check the pop, advance the model, check registered outputs.
    task automatic cycle(input logic en, input logic emp, input logic r);
        int h, v;
        logic run, act, e_rreq, e_bl, e_hs, e_vs, e_fs, e_uf;
        logic [23:0] e_rgb;
        @(negedge clk);
        enable     = en;
        fifo_empty = emp;
        rst        = r;
        fifo_data  = 24'($urandom);
        #1;
        h   = m_pos % HT;
        v   = m_pos / HT;
        run = (m_mode == M_RUN);
        act = (h < 8) && (v < 4);
        e_rreq = !r && run && act && !emp;
        chk("rreq_a", 32'(rreq_a), 32'(e_rreq));
        chk("rreq_b", 32'(rreq_b), 32'(e_rreq));

        if (r) begin
            e_rgb = '0; e_bl = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
            e_fs = 1'b0; e_uf = 1'b0; h = 0; v = 0;
            m_mode = M_IDLE; m_pos = 0; m_ufl = 0;
        end else begin
            e_rgb = e_rreq ? fifo_data : 24'h0;
            e_bl  = run && act;
            e_hs  = !(run && h >= 10 && h <= 12);
            e_vs  = !(run && v >= 5 && v <= 6);
            e_fs  = run && (m_pos == 0);
            e_uf  = run && act && emp;
            if (e_uf) m_ufl++;
            case (m_mode)
                M_IDLE:  if (en) m_mode = M_PRIME;
                M_PRIME: if (!en) m_mode = M_IDLE; else if (!emp) m_mode = M_RUN;
                default: begin
                    if (m_pos == FRAME - 1) begin
                        m_pos = 0;
                        if (!en) m_mode = M_IDLE;
                    end else begin
                        m_pos++;
                    end
                end
            endcase
        end

        @(posedge clk);
        #1;
        chk("rgb_a",   32'({r_a, g_a, b_a}), 32'(e_rgb));
        chk("blank_a", 32'(bl_a), 32'(e_bl));
        chk("hsync_a", 32'(hs_a), 32'(e_hs));
        chk("vsync_a", 32'(vs_a), 32'(e_vs));
        chk("syncn_a", 32'(sn_a), 32'd1);
        chk("pixx_a",  32'(x_a), 32'(h));
        chk("pixy_a",  32'(y_a), 32'(v));
        chk("fstart_a", 32'(fs_a), 32'(e_fs));
        chk("ufl_a",   32'(uf_a), 32'(e_uf));
        chk("ucnt_a",  32'(cnt_a), 32'((m_ufl > 65535) ? 65535 : m_ufl));
        chk("rgb_b",   32'({r_b, g_b, b_b}), 32'(e_rgb));
        chk("blank_b", 32'(bl_b), 32'(e_bl));
        chk("hsync_b", 32'(hs_b), 32'(e_hs));
        chk("vsync_b", 32'(vs_b), 32'(e_vs));
        chk("syncn_b", 32'(sn_b), 32'd1);
        chk("pixx_b",  32'(x_b), 32'(h));
        chk("pixy_b",  32'(y_b), 32'(v));
        chk("fstart_b", 32'(fs_b), 32'(e_fs));
        chk("ufl_b",   32'(uf_b), 32'(e_uf));
        chk("ucnt_b",  32'(cnt_b), 32'((m_ufl > 3) ? 3 : m_ufl));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        // reset state
        repeat (2) cycle(1'b0, 1'b1, 1'b1);
        // steady streaming with a full FIFO for two-plus frames
        repeat (300) cycle(1'b1, 1'b0, 1'b0);
        // enable dropped mid-frame: frame completes then idles
        repeat (150) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        // prime with an empty FIFO, then release
        repeat (20) cycle(1'b1, 1'b1, 1'b0);
        repeat (200) cycle(1'b1, 1'b0, 1'b0);
        // sporadic underflow while running
        repeat (400) cycle(1'b1, 1'($urandom_range(0, 7) == 0), 1'b0);
        // reset mid-frame, then restart
        cycle(1'b1, 1'b0, 1'b1);
        repeat (150) cycle(1'b1, 1'($urandom_range(0, 5) == 0), 1'b0);
        // fully random control
        repeat (700) cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 199) == 0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
